// File: rtl/trigger_pkg.sv
// Shared widths, bus offsets and helpers for the trigger conditioner.
// Contents:
//   NUM_DIGIN / NUM_ADC / NUM_SW  - field widths of the trigger bus
//   DIGIN_LSB / ADC_LSB / SW_LSB  - field offsets within the bus
//   TRIG_W                        - total trigger bus width
//   TICK_STATE_DEFAULT            - default frame-update main_state value
//   sw_load_value()               - software pulse length, 0 mapped to 1
package trigger_pkg;

    localparam int unsigned NUM_DIGIN = 16;
    localparam int unsigned NUM_ADC   = 8;
    localparam int unsigned NUM_SW    = 8;

    localparam int unsigned DIGIN_LSB = 0;
    localparam int unsigned ADC_LSB   = 16;
    localparam int unsigned SW_LSB    = 24;

    localparam int unsigned TRIG_W    = 32;

    localparam logic [31:0] TICK_STATE_DEFAULT = 32'd98;

    // A programmed length of zero still produces a one-frame pulse.
    function automatic logic [7:0] sw_load_value(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd1 : frames;
    endfunction

endpackage

// File: rtl/trig_debounce.sv
// Single digital trigger input: 2-flop synchroniser followed by an
// optional frame-based debounce counter.
// Build option: TRIG_DEBOUNCE_EN - when defined, the debounce counter is
// built; otherwise the synchronised input is sampled directly on each tick.
// Ports:
//   clk_i              system clock
//   reset_i            synchronous active-high reset
//   din_i              raw asynchronous input bit
//   tick_i             frame-update strobe
//   debounce_frames_i  extra consecutive frames a change must persist
//   trig_o             conditioned (registered) trigger bit
module trig_debounce (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       din_i,
    input  logic       tick_i,
    input  logic [3:0] debounce_frames_i,
    output logic       trig_o
);

    logic [1:0] sync_q;
    logic       din_s;
    logic       trig_q;
    logic       trig_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], din_i};
        end
    end

    assign din_s = sync_q[1];

`ifdef TRIG_DEBOUNCE_EN
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        trig_d = trig_q;
        cnt_d  = cnt_q;
        if (tick_i) begin
            if (din_s == trig_q) begin
                cnt_d = '0;
            end else if (cnt_q >= debounce_frames_i) begin
                trig_d = din_s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            trig_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            trig_q <= trig_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    logic debounce_unused;
    assign debounce_unused = ^debounce_frames_i;

    always_comb begin
        trig_d = tick_i ? din_s : trig_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end
`endif

    assign trig_o = trig_q;

endmodule

// File: rtl/trigger_conditioner.sv
// Builds the 32-bit trigger bus for the output/stimulation sequencers.
// All bus fields update once per frame on the tick cycle
// (channel == 0 && main_state == TICK_STATE) and are registered.
// Build option: TRIG_DEBOUNCE_EN (inside trig_debounce) enables the
// digital-input debounce counters.
// Ports:
//   dataclk          system clock
//   reset            synchronous active-high reset
//   main_state       global frame state counter
//   channel          global channel counter
//   digin            raw asynchronous digital inputs
//   adc_above        ADC threshold flags (dataclk domain)
//   sw_trig_word     software-trigger bit mask
//   sw_trig_strobe   one-cycle pulse latching sw_trig_word
//   debounce_frames  debounce length in extra frames
//   sw_trig_frames   software pulse length in frames (0 acts as 1)
//   triggers         [15:0] digin, [23:16] ADC, [31:24] software
//   frame_tick       one-cycle pulse when triggers has just updated
module trigger_conditioner
    import trigger_pkg::*;
#(
    parameter logic [31:0] TICK_STATE = TICK_STATE_DEFAULT
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic [31:0]          main_state,
    input  logic [5:0]           channel,
    input  logic [NUM_DIGIN-1:0] digin,
    input  logic [NUM_ADC-1:0]   adc_above,
    input  logic [NUM_SW-1:0]    sw_trig_word,
    input  logic                 sw_trig_strobe,
    input  logic [3:0]           debounce_frames,
    input  logic [7:0]           sw_trig_frames,
    output logic [TRIG_W-1:0]    triggers,
    output logic                 frame_tick
);

    logic tick;
    assign tick = (channel == 6'd0) && (main_state == TICK_STATE);

    // Digital inputs
    logic [NUM_DIGIN-1:0] dig_trig;

    for (genvar g = 0; g < NUM_DIGIN; g++) begin : g_dig
        trig_debounce u_deb (
            .clk_i             (dataclk),
            .reset_i           (reset),
            .din_i             (digin[g]),
            .tick_i            (tick),
            .debounce_frames_i (debounce_frames),
            .trig_o            (dig_trig[g])
        );
    end

    // ADC flags and frame tick
    logic [NUM_ADC-1:0] adc_q;
    logic [NUM_ADC-1:0] adc_d;
    logic               frame_tick_q;

    always_comb begin
        adc_d = tick ? adc_above : adc_q;
    end

    // Software triggers
    logic [NUM_SW-1:0] sw_pending_q;
    logic [NUM_SW-1:0] sw_pending_d;
    logic [7:0]        swcnt_q [NUM_SW];
    logic [7:0]        swcnt_d [NUM_SW];
    logic [NUM_SW-1:0] sw_trig_q;
    logic [NUM_SW-1:0] sw_trig_d;

    always_comb begin
        sw_pending_d = sw_pending_q;
        swcnt_d      = swcnt_q;
        sw_trig_d    = sw_trig_q;
        if (tick) begin
            for (int unsigned j = 0; j < NUM_SW; j++) begin
                if (sw_pending_q[j]) begin
                    swcnt_d[j] = sw_load_value(sw_trig_frames);
                end else if (swcnt_q[j] != 8'd0) begin
                    swcnt_d[j] = swcnt_q[j] - 8'd1;
                end
                sw_trig_d[j] = (swcnt_d[j] != 8'd0);
            end
            sw_pending_d = '0;
        end
        // Applied after the tick clear so a coincident strobe waits for the next tick.
        if (sw_trig_strobe) begin
            sw_pending_d = sw_pending_d | sw_trig_word;
        end
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            adc_q        <= '0;
            frame_tick_q <= 1'b0;
            sw_pending_q <= '0;
            swcnt_q      <= '{default: '0};
            sw_trig_q    <= '0;
        end else begin
            adc_q        <= adc_d;
            frame_tick_q <= tick;
            sw_pending_q <= sw_pending_d;
            swcnt_q      <= swcnt_d;
            sw_trig_q    <= sw_trig_d;
        end
    end

    assign triggers[DIGIN_LSB +: NUM_DIGIN] = dig_trig;
    assign triggers[ADC_LSB   +: NUM_ADC]   = adc_q;
    assign triggers[SW_LSB    +: NUM_SW]    = sw_trig_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed self-checking bench for trigger_conditioner.
// Frame of 10 states (main_state 0..9), tick at main_state == 6.
module tb_trigger_conditioner;

`ifdef TRIG_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    localparam int TICK = 6;
    localparam int FRAME = 10;

    logic        dataclk = 1'b0;
    logic        reset;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] digin;
    logic [7:0]  adc_above;
    logic [7:0]  sw_trig_word;
    logic        sw_trig_strobe;
    logic [3:0]  debounce_frames;
    logic [7:0]  sw_trig_frames;
    logic [31:0] triggers;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;
    int ms = 0;
    bit gate_off = 1'b0;

    trigger_conditioner #(.TICK_STATE(32'd6)) dut (
        .dataclk         (dataclk),
        .reset           (reset),
        .main_state      (main_state),
        .channel         (channel),
        .digin           (digin),
        .adc_above       (adc_above),
        .sw_trig_word    (sw_trig_word),
        .sw_trig_strobe  (sw_trig_strobe),
        .debounce_frames (debounce_frames),
        .sw_trig_frames  (sw_trig_frames),
        .triggers        (triggers),
        .frame_tick      (frame_tick)
    );

    always #5 dataclk = ~dataclk;

    // Advance one cycle: wait for the falling edge, then set up the frame
    // counters for the next rising edge.
    task automatic step();
        @(negedge dataclk);
        ms = (ms == FRAME - 1) ? 0 : ms + 1;
        main_state = 32'(ms);
        channel = (gate_off && ms == TICK) ? 6'd1 : 6'd0;
    endtask

    // Run until the cycle just after the next tick edge.
    task automatic after_tick();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (ms != TICK && k < 3 * FRAME);
        if (k >= 3 * FRAME) begin
            n_cmp++; n_err++;
            $display("FAIL tick_timeout: got no tick after %0d cycles, want one", k);
        end
        step();
    endtask

    task automatic goto_tick_cycle();
        do step(); while (ms != TICK);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        digin = 16'hFFFF;
        after_tick();
        n_cmp++;
        if (triggers !== 32'h0) begin
            n_err++; $display("FAIL reset_triggers: got %h want %h", triggers, 32'h0);
        end
        n_cmp++;
        if (frame_tick !== 1'b0) begin
            n_err++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
        end
        reset = 1'b0;
        debounce_frames = 4'd0;
        step();
        n_cmp++;
        if (triggers[15:0] !== 16'h0000) begin
            n_err++; $display("FAIL pre_tick_dig: got %h want 0000", triggers[15:0]);
        end
        after_tick();
        n_cmp++;
        if (triggers[15:0] !== 16'hFFFF) begin
            n_err++; $display("FAIL first_tick_dig: got %h want ffff", triggers[15:0]);
        end
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_err++; $display("FAIL frame_tick_pulse: got %b want 1", frame_tick);
        end
        step();
        n_cmp++;
        if (frame_tick !== 1'b0 || triggers[15:0] !== 16'hFFFF) begin
            n_err++; $display("FAIL frame_tick_single: got %b/%h want 0/ffff", frame_tick, triggers[15:0]);
        end
    endtask

    task automatic test_debounce();
        logic exp;
        digin = 16'h0000;
        debounce_frames = 4'd0;
        after_tick();
        n_cmp++;
        if (triggers[15:0] !== 16'h0000) begin
            n_err++; $display("FAIL dig_clear: got %h want 0000", triggers[15:0]);
        end
        debounce_frames = 4'd3;
        digin = 16'h0020;
        for (int k = 1; k <= 3; k++) begin
            after_tick();
            exp = DB ? 1'b0 : 1'b1;
            n_cmp++;
            if (triggers[5] !== exp) begin
                n_err++; $display("FAIL deb_short_%0d: got %b want %b", k, triggers[5], exp);
            end
        end
        digin = 16'h0000;
        for (int k = 1; k <= 2; k++) begin
            after_tick();
            n_cmp++;
            if (triggers[5] !== 1'b0) begin
                n_err++; $display("FAIL deb_drop_%0d: got %b want 0", k, triggers[5]);
            end
        end
        digin = 16'h0020;
        for (int k = 1; k <= 4; k++) begin
            after_tick();
            exp = DB ? (k == 4) : 1'b1;
            n_cmp++;
            if (triggers[15:0] !== {10'b0, exp, 5'b0}) begin
                n_err++; $display("FAIL deb_hold_%0d: got %h want %h", k, triggers[15:0], {10'b0, exp, 5'b0});
            end
        end
    endtask

    task automatic test_adc();
        adc_above = 8'hA5;
        step();
        n_cmp++;
        if (triggers[23:16] !== 8'h00) begin
            n_err++; $display("FAIL adc_before_tick: got %h want 00", triggers[23:16]);
        end
        after_tick();
        n_cmp++;
        if (triggers[23:16] !== 8'hA5) begin
            n_err++; $display("FAIL adc_after_tick: got %h want a5", triggers[23:16]);
        end
        adc_above = 8'h3C;
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if (triggers[23:16] !== 8'hA5) begin
            n_err++; $display("FAIL adc_hold: got %h want a5", triggers[23:16]);
        end
        after_tick();
        n_cmp++;
        if (triggers[23:16] !== 8'h3C) begin
            n_err++; $display("FAIL adc_next: got %h want 3c", triggers[23:16]);
        end
    endtask

    task automatic test_channel_gate();
        gate_off = 1'b1;
        adc_above = 8'h81;
        after_tick();
        n_cmp++;
        if (triggers[23:16] !== 8'h3C || frame_tick !== 1'b0) begin
            n_err++; $display("FAIL chan_gate: got %h/%b want 3c/0", triggers[23:16], frame_tick);
        end
        gate_off = 1'b0;
        after_tick();
        n_cmp++;
        if (triggers[23:16] !== 8'h81) begin
            n_err++; $display("FAIL chan_ungate: got %h want 81", triggers[23:16]);
        end
    endtask

    task automatic test_sw_pulse();
        logic [2:0] exp;
        logic [2:0] got;
        sw_trig_frames = 8'd2;
        sw_trig_word = 8'h01;
        sw_trig_strobe = 1'b1;
        step();
        sw_trig_strobe = 1'b0;
        n_cmp++;
        if (triggers[31:24] !== 8'h00) begin
            n_err++; $display("FAIL sw_before_tick: got %h want 00", triggers[31:24]);
        end
        exp = 3'b011;
        for (int k = 0; k < 3; k++) begin
            after_tick();
            got[k] = triggers[24];
        end
        n_cmp++;
        if (got !== exp || triggers[31:25] !== 7'h0) begin
            n_err++; $display("FAIL sw_len2: got %b want %b", got, exp);
        end
        sw_trig_frames = 8'd0;
        sw_trig_word = 8'h02;
        sw_trig_strobe = 1'b1;
        step();
        sw_trig_strobe = 1'b0;
        exp = 3'b001;
        for (int k = 0; k < 3; k++) begin
            after_tick();
            got[k] = triggers[25];
        end
        n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL sw_len0: got %b want %b", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        logic [3:0] got;
        sw_trig_frames = 8'd1;
        sw_trig_word = 8'h10;
        goto_tick_cycle();
        sw_trig_strobe = 1'b1;
        step();
        sw_trig_strobe = 1'b0;
        n_cmp++;
        if (triggers[28] !== 1'b0) begin
            n_err++; $display("FAIL strobe_at_tick_early: got %b want 0", triggers[28]);
        end
        after_tick();
        n_cmp++;
        if (triggers[28] !== 1'b1) begin
            n_err++; $display("FAIL strobe_at_tick_late: got %b want 1", triggers[28]);
        end
        after_tick();
        sw_trig_frames = 8'd3;
        sw_trig_word = 8'h04;
        sw_trig_strobe = 1'b1;
        step();
        sw_trig_strobe = 1'b0;
        after_tick();
        after_tick();
        n_cmp++;
        if (triggers[26] !== 1'b1) begin
            n_err++; $display("FAIL retrig_active: got %b want 1", triggers[26]);
        end
        sw_trig_strobe = 1'b1;
        step();
        sw_trig_strobe = 1'b0;
        exp = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            after_tick();
            got[k] = triggers[26];
        end
        n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL retrig_extend: got %b want %b", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        digin = 16'h0000;
        debounce_frames = 4'd0;
        adc_above = 8'h00;
        after_tick();
        sw_trig_frames = 8'd5;
        sw_trig_word = 8'h08;
        sw_trig_strobe = 1'b1;
        debounce_frames = 4'd3;
        digin = 16'h0080;
        step();
        sw_trig_strobe = 1'b0;
        after_tick();
        n_cmp++;
        if (triggers[27] !== 1'b1) begin
            n_err++; $display("FAIL mid_pulse_on: got %b want 1", triggers[27]);
        end
        after_tick();
        reset = 1'b1;
        step();
        n_cmp++;
        if (triggers !== 32'h0 || frame_tick !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got %h/%b want 0/0", triggers, frame_tick);
        end
        step();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            after_tick();
            exp = DB ? (k == 4) : 1'b1;
            n_cmp++;
            if (triggers[27] !== 1'b0 || triggers[7] !== exp) begin
                n_err++; $display("FAIL post_reset_%0d: got sw=%b dig=%b want sw=0 dig=%b", k, triggers[27], triggers[7], exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        main_state = 32'd0;
        channel = 6'd0;
        digin = 16'h0000;
        adc_above = 8'h00;
        sw_trig_word = 8'h00;
        sw_trig_strobe = 1'b0;
        debounce_frames = 4'd0;
        sw_trig_frames = 8'd0;
        test_reset();
        test_debounce();
        test_adc();
        test_channel_gate();
        test_sw_pulse();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_conditioner.md
# trigger_conditioner

Builds the 32-bit `triggers` bus consumed by the digital-output and stimulation sequencers. Raw digital inputs are synchronised and debounced, ADC threshold flags are registered, and host software triggers are stretched to a programmable number of frames. All updates happen once per sample frame, one cycle before sequencers sample the bus, so every sequencer in a frame sees an identical, glitch-free trigger word.

## Interface
Parameters:
- TICK_STATE, 98, `main_state` value at which the frame update occurs when `channel` == 0.

Ports:
- dataclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- main_state  in  32  global frame state counter.
- channel  in  6  global channel counter.
- digin  in  16  raw asynchronous digital inputs.
- adc_above  in  8  ADC threshold comparator flags, already in the `dataclk` domain.
- sw_trig_word  in  8  host software-trigger bit mask.
- sw_trig_strobe  in  1  single-cycle pulse that latches `sw_trig_word`.
- debounce_frames  in  4  number of extra consecutive frames a changed input must persist.
- sw_trig_frames  in  8  software-trigger pulse length in frames; 0 is treated as 1.
- triggers  out  32  conditioned trigger bus:
  - [15:0] digital inputs.
  - [23:16] ADC flags.
  - [31:24] software triggers.
- frame_tick  out  1  one-cycle pulse marking the cycle in which `triggers` has just updated.

## Operation
- **Synchroniser:** `digin` passes through a 2-flop synchroniser every cycle, giving `din_s`.
- **Tick:** `tick` = (`channel` == 0) && (`main_state` == TICK_STATE). All state below changes only on `tick`, except the synchroniser and `sw_pending`.
- **Digital bits i = 0..15:** each bit has a 4-bit counter `cnt[i]`. On `tick`:
  - If `din_s[i]` == `triggers[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i]` >= `debounce_frames`: `triggers[i]` <= `din_s[i]` and `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]` + 1.
  - Result: with `debounce_frames` = N, a change is accepted on the (N+1)th consecutive differing tick. A single matching tick restarts the count.
- **ADC bits:** on `tick`, `triggers[23:16]` <= `adc_above`.
- **Software bits j = 0..7:**
  - On `sw_trig_strobe`, `sw_pending` |= `sw_trig_word`.
  - On `tick`, each pending bit loads `swcnt[j]` <= max(`sw_trig_frames`, 1) and clears its pending flag. Each non-pending bit with `swcnt[j]` != 0 decrements.
  - `triggers[24+j]` <= (next `swcnt[j]` != 0).
  - A retrigger while a pulse is active reloads the counter, extending the pulse rather than adding to it.
- **Simultaneous strobe and tick:** the strobe bits are OR-ed into pending and serviced at the next tick. The strobe is never lost, and it does not clear pending bits being serviced in the same cycle.
- **Reset values:** `triggers` = 0, `frame_tick` = 0, all `cnt`/`swcnt` = 0, `sw_pending` = 0, synchroniser flops = 0.
- **Reset mid-pulse:** the software pulse and any debounce progress are discarded.

## Timing
- `digin` to `din_s`: 2 cycles. The input must be settled at least 2 cycles before the tick cycle to count in that frame.
- `triggers` and `frame_tick` are registered and change only in the cycle after `tick`. The bus is then constant for the rest of the frame.
- With TICK_STATE = 98, `triggers` is stable before consumers sample at states 99/100.
- Software trigger: a strobe at cycle t, before a tick at t' > t, makes the bit high from t'+1 for exactly max(`sw_trig_frames`, 1) frames.
- `debounce_frames` and `sw_trig_frames` are sampled at each tick. Changing them mid-count takes effect at the next tick; no reset is required.

## Configuration
- `TRIG_DEBOUNCE_EN` defined: the digital-bit debounce counters described above are built.
- Not defined:
  - `triggers[15:0]` <= `din_s` on every tick; `debounce_frames` is ignored.
  - No `cnt` registers are synthesised.
  - Synchroniser, ADC and software paths are unchanged.

## Structure
- Shared package `trigger_pkg` holds:
  - Widths: NUM_DIGIN = 16, NUM_ADC = 8, NUM_SW = 8.
  - Bus offsets: DIGIN_LSB = 0, ADC_LSB = 16, SW_LSB = 24.
  - TRIG_W = 32 and the default TICK_STATE.
- Sub-module `trig_debounce`: a single-bit synchroniser plus debounce counter, instantiated 16 times via generate. It contains the `TRIG_DEBOUNCE_EN` conditional.

## Test plan
- Reset, then drive `digin` = 16'hFFFF → `triggers` stays 0 during reset; after release with `debounce_frames` = 0, `triggers[15:0]` = 16'hFFFF one cycle after the first tick that sees the synchronised value.
- `debounce_frames` = 3, raise `digin[5]` for 3 frames then drop it → `triggers[5]` never rises. Hold it for 4 frames → rises after the 4th tick.
- `adc_above` = 8'hA5 → `triggers[23:16]` = 8'hA5 in the cycle after the next tick, with no change between ticks.
- `sw_trig_frames` = 2, strobe `sw_trig_word` = 8'h01 → `triggers[24]` high for exactly 2 frames. `sw_trig_frames` = 0 → high for 1 frame.
- Strobe in the same cycle as a tick → bit rises after the following tick. Retrigger during an active pulse → pulse extended to `sw_trig_frames` from the retrigger tick.
- Assert `reset` mid software pulse and mid debounce → all outputs 0 next cycle, and the pulse does not resume after release.
